audio_sample_channel: RTL and testbench

Single audio playback channel that consumes the one-cycle `timer_interrupt` tick of the channel's sample-rate Timer. It fetches 16-bit PCM samples from memory over a req/ack port and applies an 8-bit volume. On each tick it presents the next scaled sample to the downstream mixer. It supports one-shot and looped playback, and raises a completion pulse and a sticky underrun flag.

---
 rtl/audio_sample_channel.sv | 156 +++++++++++++++
 tb/tb_audio_sample_channel.sv | 436 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_sample_channel.sv
// Single audio playback channel: fetches 16-bit PCM samples over a req/ack port,
// scales them by an 8-bit volume and presents one sample per sample-rate tick.
module audio_sample_channel #(
  parameter int ADDR_WIDTH = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  write,
  input  logic [1:0]            reg_sel,
  input  logic [31:0]           data_in,
  input  logic                  tick,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_ack,
  input  logic [15:0]           mem_data,
  output logic [15:0]           sample_out,
  output logic                  sample_valid,
  output logic                  playing,
  output logic                  done_irq,
  output logic                  underrun
);

  typedef enum logic [1:0] {IDLE, FETCH, WAIT_TICK} state_t;

  state_t r_state;
  state_t w_nextState;

  logic [ADDR_WIDTH-1:0] r_startAddr;
  logic [ADDR_WIDTH-1:0] r_shStart;
  logic [31:0]           r_length;
  logic [31:0]           r_shLen;
  logic [31:0]           r_pos;
  logic [7:0]            r_volume;
  logic                  r_loop;
  logic                  r_abort;
  logic [15:0]           r_buffer;
  logic [15:0]           r_sampleOut;
  logic                  r_sampleValid;
  logic                  r_doneIrq;
  logic                  r_underrun;

  logic w_ctrlWr, w_enableWr, w_disableWr;
  logic w_start, w_startEmpty, w_fetchDone, w_emit, w_wrap, w_finish;
  logic signed [23:0] w_product;

  assign w_ctrlWr    = write && (reg_sel == 2'd3);
  assign w_enableWr  = w_ctrlWr && data_in[0];
  assign w_disableWr = w_ctrlWr && !data_in[0];

  // Signed 16 x unsigned 8 always fits in 24 signed bits.
  assign w_product = $signed(r_buffer) * $signed({1'b0, r_volume});

  assign mem_req      = (r_state == FETCH);
  assign mem_addr     = mem_req ? (r_shStart + r_pos[ADDR_WIDTH-1:0]) : '0;
  assign playing      = (r_state != IDLE);
  assign sample_out   = r_sampleOut;
  assign sample_valid = r_sampleValid;
  assign done_irq     = r_doneIrq;
  assign underrun     = r_underrun;

  always_ff @(posedge clk) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_nextState;
  end

  always_comb begin
    w_nextState  = r_state;
    w_start      = 1'b0;
    w_startEmpty = 1'b0;
    w_fetchDone  = 1'b0;
    w_emit       = 1'b0;
    w_wrap       = 1'b0;
    w_finish     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_enableWr) begin
          if (r_length == 32'd0) begin
            w_startEmpty = 1'b1;
          end else begin
            w_start     = 1'b1;
            w_nextState = FETCH;
          end
        end
      end
      FETCH: begin
        // An aborted fetch still completes its handshake, then the data is dropped.
        if (mem_ack) begin
          if (r_abort || w_disableWr) begin
            w_nextState = IDLE;
          end else begin
            w_fetchDone = 1'b1;
            w_nextState = WAIT_TICK;
          end
        end
      end
      WAIT_TICK: begin
        if (w_disableWr) begin
          w_nextState = IDLE;
        end else if (tick) begin
          w_emit = 1'b1;
          if (r_pos != r_shLen) begin
            w_nextState = FETCH;
          end else if (r_loop && (r_length != 32'd0)) begin
            w_wrap      = 1'b1;
            w_nextState = FETCH;
          end else begin
            w_finish    = 1'b1;
            w_nextState = IDLE;
          end
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_startAddr   <= '0;
      r_shStart     <= '0;
      r_length      <= '0;
      r_shLen       <= '0;
      r_pos         <= '0;
      r_volume      <= '0;
      r_loop        <= 1'b0;
      r_abort       <= 1'b0;
      r_buffer      <= '0;
      r_sampleOut   <= '0;
      r_sampleValid <= 1'b0;
      r_doneIrq     <= 1'b0;
      r_underrun    <= 1'b0;
    end else begin
      r_sampleValid <= w_emit;
      r_doneIrq     <= w_finish | w_startEmpty;
      if (write && (reg_sel == 2'd0)) r_startAddr <= data_in[ADDR_WIDTH-1:0];
      if (write && (reg_sel == 2'd1)) r_length <= data_in;
      if (write && (reg_sel == 2'd2)) r_volume <= data_in[7:0];
      if (w_ctrlWr) r_loop <= data_in[1];
      if (w_start || w_startEmpty || w_wrap) begin
        r_shStart <= r_startAddr;
        r_shLen   <= r_length;
        r_pos     <= '0;
      end
      if (w_fetchDone) begin
        r_buffer <= mem_data;
        r_pos    <= r_pos + 32'd1;
      end
      if (w_emit) r_sampleOut <= 16'(w_product >>> 8);
      if ((r_state == FETCH) && !mem_ack) r_abort <= r_abort | w_disableWr;
      else                                r_abort <= 1'b0;
      // A tick that lands on the same edge as a clear still records the underrun.
      if ((r_state == FETCH) && tick)      r_underrun <= 1'b1;
      else if (w_ctrlWr && data_in[2])     r_underrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_audio_sample_channel.sv
// Scoreboard bench for audio_sample_channel: a memory responder acks fetches,
// a negedge monitor collects outputs, and each test compares them to expectations.
module tb_audio_sample_channel;

  localparam int AW = 24;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          write = 1'b0;
  logic [1:0]    reg_sel = 2'd0;
  logic [31:0]   data_in = 32'd0;
  logic          tick = 1'b0;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_ack = 1'b0;
  logic [15:0]   mem_data = 16'd0;
  logic [15:0]   sample_out;
  logic          sample_valid;
  logic          playing;
  logic          done_irq;
  logic          underrun;

  int total = 0;
  int bad = 0;

  int          ackDelay = 2;
  int          reqAge = 0;
  logic        respEnable = 1'b1;
  logic        forceAck = 1'b0;
  logic [15:0] forceData = 16'd0;
  logic [15:0] memArr [0:255];

  logic [15:0]   expSample[$];
  logic [15:0]   obsSample[$];
  logic [AW-1:0] expAddr[$];
  logic [AW-1:0] obsAddr[$];
  int doneCnt = 0;
  int doneWithValid = 0;
  int reqCycles = 0;

  audio_sample_channel #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .write(write), .reg_sel(reg_sel), .data_in(data_in),
    .tick(tick), .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_data(mem_data), .sample_out(sample_out), .sample_valid(sample_valid),
    .playing(playing), .done_irq(done_irq), .underrun(underrun)
  );

  always #5 clk = ~clk;

  // Monitor samples outputs first, then the responder updates the ack it drives.
  always @(negedge clk) begin
    if (sample_valid) begin
      obsSample.push_back(sample_out);
      if (done_irq) doneWithValid++;
    end
    if (done_irq) doneCnt++;
    if (mem_req) reqCycles++;
    if (mem_ack) begin
      mem_ack = 1'b0;
      reqAge  = 0;
    end else if (forceAck) begin
      mem_ack  = 1'b1;
      mem_data = forceData;
    end else if (mem_req && respEnable) begin
      if (reqAge >= ackDelay) begin
        mem_ack  = 1'b1;
        mem_data = memArr[mem_addr[7:0]];
        obsAddr.push_back(mem_addr);
      end else begin
        reqAge++;
      end
    end else begin
      reqAge = 0;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic writeReg(input logic [1:0] sel, input logic [31:0] d);
    write   = 1'b1;
    reg_sel = sel;
    data_in = d;
    @(negedge clk);
    write   = 1'b0;
    data_in = 32'd0;
  endtask

  task automatic tickPulse();
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
  endtask

  task automatic clearObs();
    expSample.delete();
    obsSample.delete();
    expAddr.delete();
    obsAddr.delete();
    doneCnt = 0;
    doneWithValid = 0;
    reqCycles = 0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle(3);
    total++;
    if ({mem_req, sample_valid, playing, done_irq, underrun} !== 5'b0) begin
      bad++;
      $display("FAIL reset_flags got %b exp 00000", {mem_req, sample_valid, playing, done_irq, underrun});
    end
    total++;
    if (sample_out !== 16'h0000) begin
      bad++;
      $display("FAIL reset_sample got %h exp 0000", sample_out);
    end
    total++;
    if (mem_addr !== 24'h0) begin
      bad++;
      $display("FAIL reset_addr got %h exp 000000", mem_addr);
    end
    rst = 1'b1;
    idle(2);
    total++;
    if (playing !== 1'b0) begin
      bad++;
      $display("FAIL reset_release_playing got %b exp 0", playing);
    end
  endtask

  task automatic test_one_shot();
    clearObs();
    ackDelay = 2;
    memArr[0] = 16'h4000;
    memArr[1] = 16'hC000;
    memArr[2] = 16'h0100;
    expSample.push_back(16'h2000);
    expSample.push_back(16'hE000);
    expSample.push_back(16'h0080);
    expAddr.push_back(24'h100);
    expAddr.push_back(24'h101);
    expAddr.push_back(24'h102);
    writeReg(2'd0, 32'h100);
    writeReg(2'd1, 32'd3);
    writeReg(2'd2, 32'd128);
    writeReg(2'd3, 32'h1);
    total++;
    if (mem_req !== 1'b1 || playing !== 1'b1) begin
      bad++;
      $display("FAIL oneshot_start got req=%b play=%b exp req=1 play=1", mem_req, playing);
    end
    repeat (3) begin
      idle(49);
      tickPulse();
    end
    idle(3);
    foreach (expAddr[i]) begin
      total++;
      if (i >= obsAddr.size()) begin
        bad++;
        $display("FAIL oneshot_addr%0d got none exp %h", i, expAddr[i]);
      end else if (obsAddr[i] !== expAddr[i]) begin
        bad++;
        $display("FAIL oneshot_addr%0d got %h exp %h", i, obsAddr[i], expAddr[i]);
      end
    end
    foreach (expSample[i]) begin
      total++;
      if (i >= obsSample.size()) begin
        bad++;
        $display("FAIL oneshot_sample%0d got none exp %h", i, expSample[i]);
      end else if (obsSample[i] !== expSample[i]) begin
        bad++;
        $display("FAIL oneshot_sample%0d got %h exp %h", i, obsSample[i], expSample[i]);
      end
    end
    total++;
    if (doneCnt != 1 || doneWithValid != 1) begin
      bad++;
      $display("FAIL oneshot_done got cnt=%0d withValid=%0d exp 1/1", doneCnt, doneWithValid);
    end
    total++;
    if (playing !== 1'b0) begin
      bad++;
      $display("FAIL oneshot_playing got %b exp 0", playing);
    end
  endtask

  task automatic test_loop();
    clearObs();
    memArr[0] = 16'h1000;
    memArr[1] = 16'hF000;
    for (int i = 0; i < 5; i++) expSample.push_back((i % 2 == 0) ? 16'h0800 : 16'hF800);
    for (int i = 0; i < 6; i++) expAddr.push_back((i % 2 == 0) ? 24'h100 : 24'h101);
    writeReg(2'd1, 32'd2);
    writeReg(2'd3, 32'h3);
    repeat (5) begin
      idle(19);
      tickPulse();
    end
    idle(10);
    writeReg(2'd3, 32'h0);
    idle(2);
    total++;
    if (obsAddr.size() != 6) begin
      bad++;
      $display("FAIL loop_addr_count got %0d exp 6", obsAddr.size());
    end
    foreach (expAddr[i]) begin
      total++;
      if (i >= obsAddr.size()) begin
        bad++;
        $display("FAIL loop_addr%0d got none exp %h", i, expAddr[i]);
      end else if (obsAddr[i] !== expAddr[i]) begin
        bad++;
        $display("FAIL loop_addr%0d got %h exp %h", i, obsAddr[i], expAddr[i]);
      end
    end
    foreach (expSample[i]) begin
      total++;
      if (i >= obsSample.size()) begin
        bad++;
        $display("FAIL loop_sample%0d got none exp %h", i, expSample[i]);
      end else if (obsSample[i] !== expSample[i]) begin
        bad++;
        $display("FAIL loop_sample%0d got %h exp %h", i, obsSample[i], expSample[i]);
      end
    end
    total++;
    if (doneCnt != 0 || playing !== 1'b0) begin
      bad++;
      $display("FAIL loop_end got done=%0d play=%b exp 0/0", doneCnt, playing);
    end
  endtask

  task automatic test_underrun();
    clearObs();
    ackDelay = 40;
    memArr[0] = 16'h4000;
    expSample.push_back(16'h2000);
    writeReg(2'd1, 32'd1);
    writeReg(2'd3, 32'h1);
    idle(10);
    tickPulse();
    total++;
    if (underrun !== 1'b1) begin
      bad++;
      $display("FAIL underrun_set got %b exp 1", underrun);
    end
    total++;
    if (obsSample.size() != 0 || sample_out !== 16'h0800) begin
      bad++;
      $display("FAIL underrun_hold got n=%0d out=%h exp n=0 out=0800", obsSample.size(), sample_out);
    end
    for (int k = 0; k < 100 && mem_req; k++) @(negedge clk);
    total++;
    if (mem_req !== 1'b0) begin
      bad++;
      $display("FAIL underrun_ack_timeout got req=%b exp 0", mem_req);
    end
    tickPulse();
    idle(2);
    foreach (expSample[i]) begin
      total++;
      if (i >= obsSample.size()) begin
        bad++;
        $display("FAIL underrun_sample%0d got none exp %h", i, expSample[i]);
      end else if (obsSample[i] !== expSample[i]) begin
        bad++;
        $display("FAIL underrun_sample%0d got %h exp %h", i, obsSample[i], expSample[i]);
      end
    end
    total++;
    if (underrun !== 1'b1) begin
      bad++;
      $display("FAIL underrun_sticky got %b exp 1", underrun);
    end
    writeReg(2'd3, 32'h4);
    total++;
    if (underrun !== 1'b0) begin
      bad++;
      $display("FAIL underrun_clear got %b exp 0", underrun);
    end
    ackDelay = 2;
  endtask

  task automatic test_edges();
    clearObs();
    writeReg(2'd1, 32'd0);
    writeReg(2'd3, 32'h1);
    total++;
    if (done_irq !== 1'b1) begin
      bad++;
      $display("FAIL len0_done got %b exp 1", done_irq);
    end
    @(negedge clk);
    total++;
    if (done_irq !== 1'b0 || playing !== 1'b0 || reqCycles != 0) begin
      bad++;
      $display("FAIL len0_after got done=%b play=%b reqCycles=%0d exp 0/0/0", done_irq, playing, reqCycles);
    end

    clearObs();
    memArr[0] = 16'h4000;
    memArr[1] = 16'h7FFF;
    expSample.push_back(16'h0000);
    expSample.push_back(16'h0000);
    writeReg(2'd1, 32'd2);
    writeReg(2'd2, 32'd0);
    writeReg(2'd3, 32'h1);
    repeat (2) begin
      idle(9);
      tickPulse();
    end
    idle(3);
    total++;
    if (obsSample.size() != 2 || doneCnt != 1) begin
      bad++;
      $display("FAIL vol0_count got n=%0d done=%0d exp 2/1", obsSample.size(), doneCnt);
    end
    foreach (expSample[i]) begin
      total++;
      if (i >= obsSample.size()) begin
        bad++;
        $display("FAIL vol0_sample%0d got none exp %h", i, expSample[i]);
      end else if (obsSample[i] !== expSample[i]) begin
        bad++;
        $display("FAIL vol0_sample%0d got %h exp %h", i, obsSample[i], expSample[i]);
      end
    end

    clearObs();
    memArr[0] = 16'h8000;
    expSample.push_back(16'h8080);
    writeReg(2'd1, 32'd1);
    writeReg(2'd2, 32'd255);
    writeReg(2'd3, 32'h1);
    idle(9);
    tickPulse();
    idle(3);
    foreach (expSample[i]) begin
      total++;
      if (i >= obsSample.size()) begin
        bad++;
        $display("FAIL vol255_sample%0d got none exp %h", i, expSample[i]);
      end else if (obsSample[i] !== expSample[i]) begin
        bad++;
        $display("FAIL vol255_sample%0d got %h exp %h", i, obsSample[i], expSample[i]);
      end
    end
  endtask

  task automatic test_abort();
    clearObs();
    ackDelay = 20;
    writeReg(2'd1, 32'd3);
    writeReg(2'd3, 32'h1);
    idle(5);
    writeReg(2'd3, 32'h0);
    total++;
    if (mem_req !== 1'b1 || playing !== 1'b1) begin
      bad++;
      $display("FAIL abort_hold got req=%b play=%b exp 1/1", mem_req, playing);
    end
    for (int k = 0; k < 100 && mem_req; k++) @(negedge clk);
    idle(2);
    total++;
    if (playing !== 1'b0 || mem_req !== 1'b0) begin
      bad++;
      $display("FAIL abort_stop got play=%b req=%b exp 0/0", playing, mem_req);
    end
    total++;
    if (doneCnt != 0 || obsSample.size() != 0 || sample_out !== 16'h8080) begin
      bad++;
      $display("FAIL abort_quiet got done=%0d n=%0d out=%h exp 0/0/8080", doneCnt, obsSample.size(), sample_out);
    end
    ackDelay = 2;
  endtask

  task automatic test_reset_mid();
    clearObs();
    respEnable = 1'b0;
    writeReg(2'd1, 32'd2);
    writeReg(2'd2, 32'd128);
    writeReg(2'd3, 32'h1);
    idle(4);
    total++;
    if (mem_req !== 1'b1) begin
      bad++;
      $display("FAIL rstmid_pre got req=%b exp 1", mem_req);
    end
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    total++;
    if ({mem_req, playing, sample_valid, done_irq, underrun} !== 5'b0 || sample_out !== 16'h0 || mem_addr !== 24'h0) begin
      bad++;
      $display("FAIL rstmid_outputs got flags=%b out=%h addr=%h exp 0", {mem_req, playing, sample_valid, done_irq, underrun}, sample_out, mem_addr);
    end
    forceData = 16'h7FFF;
    forceAck = 1'b1;
    idle(3);
    forceAck = 1'b0;
    tickPulse();
    idle(2);
    total++;
    if (obsSample.size() != 0 || playing !== 1'b0 || mem_req !== 1'b0 || sample_out !== 16'h0) begin
      bad++;
      $display("FAIL rstmid_late_ack got n=%0d play=%b req=%b out=%h exp 0/0/0/0", obsSample.size(), playing, mem_req, sample_out);
    end
    respEnable = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) memArr[i] = 16'h0000;
    @(negedge clk);
    test_reset();
    test_one_shot();
    test_loop();
    test_underrun();
    test_edges();
    test_abort();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1);
  end

endmodule
